digit_bcd_feeder: RTL

DIGIT_BCD_FEEDER -- requirements
Module: digit_bcd_feeder

---
 rtl/digit_bcd_feeder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/digit_bcd_feeder.sv
// digit_bcd_feeder: converts a binary value to four BCD digits with the
// double-dabble algorithm (one iteration per clock) and packs them into a
// 32-bit display register word, one byte per digit.
// Optional feature: define DIGIT_LEAD_BLANK_EN to disable leading zero digits.
module digit_bcd_feeder #(
  parameter int unsigned BIN_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] binIn,
  input  logic [3:0]           dotMask,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [31:0]          digitWord
);

  localparam int unsigned CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int unsigned CMP_W = (BIN_WIDTH > 14) ? BIN_WIDTH : 14;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_WIDTH - 1);
  localparam logic [CMP_W-1:0] MAX_DISP  = CMP_W'(9999);
  localparam logic [31:0]      OVF_WORD  = 32'h2F2F2F2F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PACK  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] bin_q, bin_d;
  logic [15:0]          bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           dot_q, dot_d;
  logic                 ovf_pend_q, ovf_pend_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 overflow_q, overflow_d;
  logic [31:0]          word_q, word_d;
  logic [15:0]          bcd_adj_c;
  logic [3:0]           digit_en_c;
  logic [31:0]          pack_word_c;

  // Double-dabble correction: add 3 to every nibble that is 5 or more
  always_comb begin
    bcd_adj_c = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Digit enables: all on, or leading zero digits blanked (digit 0 always on)
  always_comb begin
    digit_en_c = 4'hF;
`ifdef DIGIT_LEAD_BLANK_EN
    digit_en_c[3] = |bcd_q[15:12];
    digit_en_c[2] = digit_en_c[3] | (|bcd_q[11:8]);
    digit_en_c[1] = digit_en_c[2] | (|bcd_q[7:4]);
    digit_en_c[0] = 1'b1;
`else
    digit_en_c = 4'hF;
`endif
  end

  // Display word assembly; an out-of-range value shows FFFF without dots
  always_comb begin
    pack_word_c = '0;
    for (int i = 0; i < 4; i++) begin
      pack_word_c[8*i +: 8] = {2'b00, digit_en_c[i], dot_q[i], bcd_q[4*i +: 4]};
    end
    if (ovf_pend_q) begin
      pack_word_c = OVF_WORD;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_ITER) state_d = PACK;
      PACK:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values per state
  always_comb begin
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    dot_d      = dot_q;
    ovf_pend_d = ovf_pend_q;
    busy_d     = (state_d != IDLE);
    done_d     = 1'b0;
    overflow_d = overflow_q;
    word_d     = word_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          bin_d      = binIn;
          dot_d      = dotMask;
          bcd_d      = '0;
          cnt_d      = '0;
          ovf_pend_d = (CMP_W'(binIn) > MAX_DISP);
        end
      end
      SHIFT: begin
        bcd_d = {bcd_adj_c[14:0], bin_q[BIN_WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
      end
      PACK: begin
        word_d     = pack_word_c;
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      dot_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      word_q     <= '0;
    end else begin
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      dot_q      <= dot_d;
      ovf_pend_q <= ovf_pend_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      word_q     <= word_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign digitWord = word_q;

endmodule
